alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port, round-robin arbiter and sequencer that shares the single combinational 8-bit ALU between two requesters, e.g. the execute stage and a future address-generation or PC-update unit. Each requester presents an opcode, operands and an immediate, then holds them under a req/done handshake. The block latches the winning request, drives the ALU for one cycle from registered operands, captures Out/Branch, and returns them to the winner with a one-cycle done pulse. It sits between the control/decode logic and the ALU instance, which it owns.

## Interface
- W, 8, data width of operands and result
- NREQ, 2, number of requesters (fixed at 2; other values unsupported)
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Req0, Req1  in  1 each  request valid; held high with stable operands until matching Done
- Op0, Op1  in  4 each  ALU opcode (shared opcode enum)
- A0, A1, B0, B1  in  W each  operands
- Im0, Im1  in  3 each  immediate / shift amount
- Gnt0, Gnt1  out  1 each  one-cycle pulse: request latched
- Done0, Done1  out  1 each  one-cycle pulse: result valid
- Result  out  W  ALU Out of the completed op, held until next completion
- BranchOut  out  1  ALU Branch of the completed op, held until next completion
- Busy  out  1  high when state is not IDLE

## Operation
- States: IDLE, EXEC, RESP (shared enum).
- IDLE: if no Req, stay. Otherwise pick a winner: only one requesting → it wins; both → the requester indicated by the round-robin pointer wins. Latch Op/A/B/Im and the winner id, set Gnt[winner] for the next cycle, go to EXEC.
- EXEC: the ALU is driven from the latched registers only. Requester inputs are ignored. Capture ALU Out → Result and Branch → BranchOut, then go to RESP.
- RESP: Done[winner]=1 for this cycle. Toggle the pointer to the non-winner, then go to IDLE.
- Pointer update: the pointer changes only on completion. If a requester still holds Req in the IDLE cycle after its RESP, that is treated as a new request.
- Requester contract: deassert Req at or before the edge ending the Done cycle if no further op is wanted. Operands must stay stable until Gnt; after Gnt they may change.
- Result/BranchOut update only on the EXEC→RESP edge. Requesters never see intermediate values.
- Unknown opcodes produce whatever the ALU outputs (Out=0, Branch=0). No error flag.
- Reset in any state:
  - next state IDLE, pointer=0, Gnt*=0, Done*=0
  - Result=0, BranchOut=0, Busy=0
  - the in-flight op is dropped with no Done
- Reset values: all outputs 0.

## Timing
- Req sampled at IDLE edge t. Gnt high in cycle t+1 (EXEC). Done, Result and BranchOut valid in cycle t+2 (RESP).
- Latency from first cycle of Req in IDLE to Done is 2 cycles. Throughput is one op per 3 cycles.
- Both requesters held continuously: grants alternate 0,1,0,1… starting with 0 after reset.
- Req arriving while Busy waits and is considered in the next IDLE cycle.
- Gnt0/Gnt1 and Done0/Done1 are mutually exclusive and never high in the same cycle as each other.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package (alongside the existing opcode enum `op_mne`):
  - `arb_state_t` enum {IDLE, EXEC, RESP}
  - `req_id_t` (1 bit)
  - localparam for the immediate width (3)
- Sub-module: one instance of the existing ALU (`ALU`), fed by the latched op/operand registers.
- Arbitration pick is a small combinational function inside this module; no separate arbiter module.

## Test plan
- Single request: Req0 with Op=ADD, A0=0x05, B0=0x03 → Gnt0 one cycle later, Done0 two cycles after first sample, Result=0x08, BranchOut=0, Done1 never asserted.
- Simultaneous after reset: Req0 (AND, 0xF0, 0x3C) and Req1 (ADD, 0x10, 0x01) both held → Done0 first with Result=0x30, then Done1 with Result=0x11. Pointer now favours 0.
- Sustained contention: both Req held for 12 cycles → exactly 4 completions, alternating 0,1,0,1, each 3 cycles apart.
- Shift/immediate path: Req1 with LSH, A1=0x81, Im1=3 → Result=0x08. Then RSH, A1=0x81, Im1=7 → Result=0x01.
- Branch: Req0 with BNZ, A0=0x00 → BranchOut=0. Then A0=0x02 → BranchOut=1. Result=0x00 in both cases.
- Reset mid-op: assert Reset during EXEC of a Req0 ADD → no Done0, all outputs 0 next cycle, state IDLE. With Req1 held, the next grant goes to Req1 only if Req0 is low.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared opcode, arbiter state and requester id types
package alu_arbiter_pkg;

  localparam int IMM_W = 3;

  typedef enum logic [3:0] {
    ADD = 4'h0,
    SUB = 4'h1,
    AND = 4'h2,
    OR  = 4'h3,
    XOR = 4'h4,
    NOT = 4'h5,
    LSH = 4'h6,
    RSH = 4'h7,
    BNZ = 4'h8,
    BIZ = 4'h9
  } op_mne;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/ALU.sv
// rtl/ALU.sv - combinational W-bit ALU with branch-condition output
module ALU
  import alu_arbiter_pkg::*;
#(
  parameter int W = 8
) (
  input  op_mne            Op,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [IMM_W-1:0] Im,
  output logic [W-1:0]     Out,
  output logic             Branch
);

  always_comb begin
    Out    = '0;
    Branch = 1'b0;
    case (Op)
      ADD:     Out = A + B;
      SUB:     Out = A - B;
      AND:     Out = A & B;
      OR:      Out = A | B;
      XOR:     Out = A ^ B;
      NOT:     Out = ~A;
      LSH:     Out = A << Im;
      RSH:     Out = A >> Im;
      // Branch ops only test A; Out stays 0.
      BNZ:     Branch = (A != '0);
      BIZ:     Branch = (A == '0);
      default: begin
        Out    = '0;
        Branch = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin sequencer sharing one ALU
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W    = 8,
  parameter int NREQ = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [3:0]       Op0,
  input  logic [3:0]       Op1,
  input  logic [W-1:0]     A0,
  input  logic [W-1:0]     A1,
  input  logic [W-1:0]     B0,
  input  logic [W-1:0]     B1,
  input  logic [IMM_W-1:0] Im0,
  input  logic [IMM_W-1:0] Im1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Done0,
  output logic             Done1,
  output logic [W-1:0]     Result,
  output logic             BranchOut,
  output logic             Busy
);

  arb_state_t       state, state_d;
  req_id_t          ptr_q, win_q, pick;
  op_mne            op_q;
  logic [W-1:0]     a_q, b_q;
  logic [IMM_W-1:0] im_q;
  logic [NREQ-1:0]  gnt_q, gnt_d, done_q, done_d;
  logic [W-1:0]     result_q, alu_out;
  logic             branch_q, alu_br, busy_q;
  logic             any_req;

  // Pointer only breaks ties; a lone requester always wins.
  function automatic req_id_t rr_pick(input logic r0, input logic r1, input req_id_t ptr);
    if (r0 && r1) return ptr;
    else if (r1)  return 1'b1;
    else          return 1'b0;
  endfunction

  assign any_req = Req0 | Req1;
  assign pick    = rr_pick(Req0, Req1, ptr_q);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      ptr_q    <= 1'b0;
      win_q    <= 1'b0;
      op_q     <= ADD;
      a_q      <= '0;
      b_q      <= '0;
      im_q     <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      branch_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state  <= state_d;
      gnt_q  <= gnt_d;
      done_q <= done_d;
      busy_q <= (state_d != IDLE);
      if (state == IDLE && any_req) begin
        win_q <= pick;
        op_q  <= op_mne'(pick ? Op1 : Op0);
        a_q   <= pick ? A1 : A0;
        b_q   <= pick ? B1 : B0;
        im_q  <= pick ? Im1 : Im0;
      end
      if (state == EXEC) begin
        result_q <= alu_out;
        branch_q <= alu_br;
      end
      if (state == RESP) ptr_q <= ~win_q;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (any_req) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered grant/done pulses.
  always_comb begin
    gnt_d  = '0;
    done_d = '0;
    if (state == IDLE && any_req) gnt_d[pick] = 1'b1;
    if (state == EXEC) done_d[win_q] = 1'b1;
  end

  ALU #(.W(W)) u_alu (
    .Op     (op_q),
    .A      (a_q),
    .B      (b_q),
    .Im     (im_q),
    .Out    (alu_out),
    .Branch (alu_br)
  );

  assign Gnt0      = gnt_q[0];
  assign Gnt1      = gnt_q[1];
  assign Done0     = done_q[0];
  assign Done1     = done_q[1];
  assign Result    = result_q;
  assign BranchOut = branch_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Req0, Req1;
  logic [3:0] Op0, Op1;
  logic [7:0] A0, A1, B0, B1;
  logic [2:0] Im0, Im1;
  logic       Gnt0, Gnt1, Done0, Done1;
  logic [7:0] Result;
  logic       BranchOut, Busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  alu_arbiter #(.W(8), .NREQ(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Req1(Req1),
    .Op0(Op0), .Op1(Op1),
    .A0(A0), .A1(A1), .B0(B0), .B1(B1),
    .Im0(Im0), .Im1(Im1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
    .Result(Result), .BranchOut(BranchOut), .Busy(Busy)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic release_all();
    Req0 = 1'b0;
    Req1 = 1'b0;
  endtask

  task automatic issue(input int id, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] im);
    if (id == 0) begin
      Req0 = 1'b1; Op0 = op; A0 = a; B0 = b; Im0 = im;
    end else begin
      Req1 = 1'b1; Op1 = op; A1 = a; B1 = b; Im1 = im;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    release_all();
    do_reset();
    n_checks++;
    if ({Gnt0, Gnt1, Done0, Done1, Result, BranchOut, Busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b%b done=%b%b res=%h br=%b busy=%b want all 0",
               Gnt0, Gnt1, Done0, Done1, Result, BranchOut, Busy);
    end
  endtask

  task automatic test_single();
    issue(0, ADD, 8'h05, 8'h03, 3'd0);
    step();
    n_checks++;
    if ({Gnt0, Gnt1, Busy, Done0} !== 4'b1010) begin
      n_fail++;
      $display("FAIL single_gnt: got gnt0=%b gnt1=%b busy=%b done0=%b want 1 0 1 0", Gnt0, Gnt1, Busy, Done0);
    end
    step();
    n_checks++;
    if ({Done0, Done1, Gnt0} !== 3'b100 || Result !== 8'h08 || BranchOut !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got done=%b%b gnt0=%b res=%h br=%b want 10 0 08 0",
               Done0, Done1, Gnt0, Result, BranchOut);
    end
    release_all();
    step();
    n_checks++;
    if ({Done0, Done1, Busy} !== 3'b000 || Result !== 8'h08) begin
      n_fail++;
      $display("FAIL single_idle: got done=%b%b busy=%b res=%h want 00 0 08", Done0, Done1, Busy, Result);
    end
    step();
    n_checks++;
    if ({Gnt0, Gnt1, Busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_no_regrant: got gnt=%b%b busy=%b want 00 0", Gnt0, Gnt1, Busy);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    issue(0, AND, 8'hF0, 8'h3C, 3'd0);
    issue(1, ADD, 8'h10, 8'h01, 3'd0);
    step();
    n_checks++;
    if ({Gnt0, Gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL simul_gnt0: got gnt=%b%b want 10", Gnt0, Gnt1);
    end
    step();
    n_checks++;
    if ({Done0, Done1} !== 2'b10 || Result !== 8'h30) begin
      n_fail++;
      $display("FAIL simul_done0: got done=%b%b res=%h want 10 30", Done0, Done1, Result);
    end
    Req0 = 1'b0;
    step();
    step();
    n_checks++;
    if ({Gnt0, Gnt1} !== 2'b01) begin
      n_fail++;
      $display("FAIL simul_gnt1: got gnt=%b%b want 01", Gnt0, Gnt1);
    end
    step();
    n_checks++;
    if ({Done0, Done1} !== 2'b01 || Result !== 8'h11) begin
      n_fail++;
      $display("FAIL simul_done1: got done=%b%b res=%h want 01 11", Done0, Done1, Result);
    end
    issue(0, OR, 8'h0F, 8'hF0, 3'd0);
    step();
    step();
    n_checks++;
    if ({Gnt0, Gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL simul_ptr_back0: got gnt=%b%b want 10", Gnt0, Gnt1);
    end
    step();
    n_checks++;
    if ({Done0, Done1} !== 2'b10 || Result !== 8'hFF) begin
      n_fail++;
      $display("FAIL simul_done0_again: got done=%b%b res=%h want 10 ff", Done0, Done1, Result);
    end
    release_all();
    step();
  endtask

  task automatic test_sustained();
    int n_done = 0;
    int last_c = -1;
    int order[4];
    do_reset();
    issue(0, ADD, 8'h01, 8'h02, 3'd0);
    issue(1, ADD, 8'h04, 8'h04, 3'd0);
    for (int c = 1; c <= 12; c++) begin
      step();
      n_checks++;
      if ((Gnt0 & Gnt1) !== 1'b0 || (Done0 & Done1) !== 1'b0) begin
        n_fail++;
        $display("FAIL sustain_exclusive: cycle %0d got gnt=%b%b done=%b%b want at most one each",
                 c, Gnt0, Gnt1, Done0, Done1);
      end
      if (Done0 === 1'b1 || Done1 === 1'b1) begin
        if (n_done < 4) order[n_done] = Done1 ? 1 : 0;
        n_checks++;
        if (Result !== (Done1 ? 8'h08 : 8'h03)) begin
          n_fail++;
          $display("FAIL sustain_result: cycle %0d got %h want %h", c, Result, Done1 ? 8'h08 : 8'h03);
        end
        n_checks++;
        if ((last_c < 0 && c !== 2) || (last_c >= 0 && c - last_c !== 3)) begin
          n_fail++;
          $display("FAIL sustain_spacing: completion at cycle %0d after %0d want first at 2 then every 3",
                   c, last_c);
        end
        last_c = c;
        n_done++;
      end
    end
    n_checks++;
    if (n_done !== 4) begin
      n_fail++;
      $display("FAIL sustain_count: got %0d completions want 4", n_done);
    end
    for (int k = 0; k < 4 && k < n_done; k++) begin
      n_checks++;
      if (order[k] !== (k % 2)) begin
        n_fail++;
        $display("FAIL sustain_order: completion %0d got id %0d want %0d", k, order[k], k % 2);
      end
    end
    release_all();
    step();
  endtask

  task automatic test_shift();
    do_reset();
    issue(1, LSH, 8'h81, 8'h00, 3'd3);
    step();
    n_checks++;
    if ({Gnt0, Gnt1} !== 2'b01) begin
      n_fail++;
      $display("FAIL lsh_gnt: got gnt=%b%b want 01", Gnt0, Gnt1);
    end
    step();
    n_checks++;
    if (Done1 !== 1'b1 || Result !== 8'h08) begin
      n_fail++;
      $display("FAIL lsh_result: got done1=%b res=%h want 1 08", Done1, Result);
    end
    release_all();
    step();
    issue(1, RSH, 8'h81, 8'h00, 3'd7);
    step();
    step();
    n_checks++;
    if (Done1 !== 1'b1 || Result !== 8'h01) begin
      n_fail++;
      $display("FAIL rsh_result: got done1=%b res=%h want 1 01", Done1, Result);
    end
    release_all();
    step();
  endtask

  task automatic test_unknown_op();
    issue(1, 4'hF, 8'hFF, 8'hFF, 3'd1);
    step();
    step();
    n_checks++;
    if (Done1 !== 1'b1 || Result !== 8'h00 || BranchOut !== 1'b0) begin
      n_fail++;
      $display("FAIL unknown_op: got done1=%b res=%h br=%b want 1 00 0", Done1, Result, BranchOut);
    end
    release_all();
    step();
  endtask

  task automatic test_branch();
    issue(0, BNZ, 8'h00, 8'h00, 3'd0);
    step();
    step();
    n_checks++;
    if (Done0 !== 1'b1 || BranchOut !== 1'b0 || Result !== 8'h00) begin
      n_fail++;
      $display("FAIL bnz_zero: got done0=%b br=%b res=%h want 1 0 00", Done0, BranchOut, Result);
    end
    release_all();
    step();
    issue(0, BNZ, 8'h02, 8'h00, 3'd0);
    step();
    step();
    n_checks++;
    if (Done0 !== 1'b1 || BranchOut !== 1'b1 || Result !== 8'h00) begin
      n_fail++;
      $display("FAIL bnz_taken: got done0=%b br=%b res=%h want 1 1 00", Done0, BranchOut, Result);
    end
    release_all();
    step();
  endtask

  task automatic test_reset_midop();
    do_reset();
    issue(0, ADD, 8'h05, 8'h03, 3'd0);
    step();
    step();
    release_all();
    step();
    issue(0, ADD, 8'h07, 8'h07, 3'd0);
    step();
    Reset = 1'b1;
    issue(1, ADD, 8'h10, 8'h01, 3'd0);
    step();
    Reset = 1'b0;
    n_checks++;
    if ({Gnt0, Gnt1, Done0, Done1, Result, BranchOut, Busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL midop_reset: got gnt=%b%b done=%b%b res=%h br=%b busy=%b want all 0",
               Gnt0, Gnt1, Done0, Done1, Result, BranchOut, Busy);
    end
    step();
    n_checks++;
    if ({Gnt0, Gnt1, Done0} !== 3'b100) begin
      n_fail++;
      $display("FAIL midop_regrant0: got gnt=%b%b done0=%b want 10 0", Gnt0, Gnt1, Done0);
    end
    step();
    n_checks++;
    if (Done0 !== 1'b1 || Result !== 8'h0E) begin
      n_fail++;
      $display("FAIL midop_done0: got done0=%b res=%h want 1 0e", Done0, Result);
    end
    Req0 = 1'b0;
    do_reset();
    step();
    n_checks++;
    if ({Gnt0, Gnt1} !== 2'b01) begin
      n_fail++;
      $display("FAIL midop_gnt1_alone: got gnt=%b%b want 01", Gnt0, Gnt1);
    end
    step();
    n_checks++;
    if (Done1 !== 1'b1 || Result !== 8'h11) begin
      n_fail++;
      $display("FAIL midop_done1: got done1=%b res=%h want 1 11", Done1, Result);
    end
    release_all();
    step();
  endtask

  initial begin
    Reset = 1'b1;
    Req0 = 1'b0; Req1 = 1'b0;
    Op0 = '0; Op1 = '0; A0 = '0; A1 = '0; B0 = '0; B1 = '0; Im0 = '0; Im1 = '0;
    step();
    test_reset();
    test_single();
    test_simultaneous();
    test_sustained();
    test_shift();
    test_unknown_op();
    test_branch();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
